// File: rtl/fns_pkg.sv
// Shared constants and types for the 20-TSV Fibonacci-numeral-system (FNS) decoder.
package fns_pkg;

  localparam int FNS_NBITS = 20;
  localparam int FBLEN20   = 15;
  localparam int FNS_MAX20 = 17710;

  typedef logic [FNS_NBITS-1:0] fns_word_t;
  typedef logic [FBLEN20-1:0]   fns_data_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DECODE = 2'd1,
    OUT    = 2'd2
  } fns_dec_state_e;

endpackage

// File: rtl/fns_ft_check.sv
// Combinational forbidden-transition checker for an FTF-coded TSV word.
// Flags any even-j 0->1 or odd-j 1->0 pair between bits j and j+1.
module fns_ft_check #(
  parameter int NBITS = 20
) (
  input  logic [NBITS-1:0] i_word,
  output logic             o_ft_err
);

  always_comb begin
    // NOTE: default assignment first so no path leaves o_ft_err unassigned (no latch).
    o_ft_err = 1'b0;
    for (int j = 0; j < NBITS - 1; j++) begin
      if ((j % 2) == 0) o_ft_err = o_ft_err | (~i_word[j] &  i_word[j+1]);
      else              o_ft_err = o_ft_err | ( i_word[j] & ~i_word[j+1]);
    end
  end

endmodule

// File: rtl/fns_serial_dec_20.sv
// Bit-serial FNS-to-binary decoder for the 20-TSV FTF bus, with valid/ready on both sides.
// Define FNS_FT_CHECK_EN to build the forbidden-transition checker and saturating error counter.
module fns_serial_dec_20
  import fns_pkg::*;
#(
  parameter int NBITS = FNS_NBITS,
  parameter int OUTW  = FBLEN20,
  parameter int ERRW  = 16
) (
  input  logic             clock,
  input  logic             rst_n,
  input  logic [NBITS-1:0] tsv,
  input  logic             s_valid,
  output logic             s_ready,
  output logic [OUTW-1:0]  dataout,
  output logic             ft_err,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [ERRW-1:0]  err_count
);

  localparam int IW = $clog2(NBITS);

  localparam logic [1:0] S_IDLE   = IDLE;
  localparam logic [1:0] S_DECODE = DECODE;
  localparam logic [1:0] S_OUT    = OUT;

  logic [1:0]       r_state;
  logic [NBITS-1:0] r_shreg;
  logic [OUTW-1:0]  r_acc;
  logic [OUTW-1:0]  r_wa;
  logic [OUTW-1:0]  r_wb;
  logic [IW-1:0]    r_idx;
  logic             w_last;

  assign w_last  = (r_state == S_DECODE) && (r_idx == IW'(NBITS - 1));
  assign s_ready = (r_state == S_IDLE);
  assign m_valid = (r_state == S_OUT);
  assign dataout = r_acc;

  // wa walks the Fibonacci sequence so it always holds the weight of shreg[0].
  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_shreg <= '0;
      r_acc   <= '0;
      r_wa    <= OUTW'(1);
      r_wb    <= OUTW'(1);
      r_idx   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (s_valid) begin
            r_shreg <= tsv;
            r_acc   <= '0;
            r_idx   <= '0;
            r_wa    <= OUTW'(1);
            r_wb    <= OUTW'(1);
            r_state <= S_DECODE;
          end
        end
        S_DECODE: begin
          if (r_shreg[0]) r_acc <= r_acc + r_wa;
          r_shreg <= r_shreg >> 1;
          r_wa    <= r_wb;
          r_wb    <= r_wa + r_wb;
          r_idx   <= r_idx + IW'(1);
          if (w_last) r_state <= S_OUT;
        end
        S_OUT: begin
          if (m_ready) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef FNS_FT_CHECK_EN
  logic [NBITS-1:0] r_word;
  logic             r_ft_err;
  logic [ERRW-1:0]  r_err_count;
  logic             w_ft_err;

  fns_ft_check #(.NBITS(NBITS)) u_ft_check (
    .i_word   (r_word),
    .o_ft_err (w_ft_err)
  );

  // The unshifted word is kept so the checker sees every bit pair, not the draining shift register.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_word      <= '0;
      r_ft_err    <= 1'b0;
      r_err_count <= '0;
    end else begin
      if (s_ready && s_valid) r_word <= tsv;
      if (w_last) r_ft_err <= w_ft_err;
      if (m_valid && m_ready && r_ft_err && (r_err_count != {ERRW{1'b1}}))
        r_err_count <= r_err_count + ERRW'(1);
    end
  end

  assign ft_err    = r_ft_err;
  assign err_count = r_err_count;
`else
  assign ft_err    = 1'b0;
  assign err_count = '0;
`endif

endmodule
